qsys_serial_endpoint: RTL and testbench

- Slave-side endpoint of the Qsys serial link. Sits directly downstream of the Qsys serial master and shares its clock domain.
- Deserialises each command frame from the master (R/W flag, address, write data), executes it as one Avalon-MM master transaction on a local register bus, then returns a 32-bit response word serially under the srdy handshake.

---
 rtl/qsys_serial_endpoint.sv | 155 +++++++++++++++
 tb/tb_qsys_serial_endpoint.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_serial_endpoint.sv
// Slave endpoint of the Qsys serial link: deserialises a command frame, runs one
// Avalon-MM transaction on the local bus and shifts a 32-bit response back.
module qsys_serial_endpoint #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic              rsi_MRST_reset,
  input  logic              csi_MCLK_clk,
  input  logic              ser_sdi,
  input  logic              ser_sle,
  output logic              ser_srdy,
  output logic              ser_sdo,
  output logic [ADDR_W-1:0] avm_local_address,
  output logic [31:0]       avm_local_writedata,
  output logic [3:0]        avm_local_byteenable,
  output logic              avm_local_write,
  output logic              avm_local_read,
  input  logic [31:0]       avm_local_readdata,
  input  logic              avm_local_waitrequest,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned FL = 1 + ADDR_W + 32;
  localparam int unsigned CW = $clog2(FL + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, CHECK, BUS_REQ, BUS_WAIT, RESP, GAP} state_t;

  state_t        state;
  logic [FL-1:0] sr;
  logic [CW-1:0] cnt;
  logic          overlong;
  logic          sle_q;
  logic          ignore;
  logic          rw;
  logic [WW-1:0] wcnt;
  logic [31:0]   resp;
  logic [4:0]    rcnt;
  logic          tmo;
  logic          sle_rise;
  logic          locked_out;
  logic [31:0]   done_word;

  assign avm_local_byteenable = 4'hF;
  assign busy       = (state != IDLE);
  assign sle_rise   = ser_sle & ~sle_q;
  assign locked_out = (state != IDLE) && (state != SHIFT_IN);
  assign tmo        = avm_local_waitrequest && (wcnt == WW'(TIMEOUT - 1));

  always_comb begin
    done_word = '0;
    if (tmo)                 done_word = ERR_WORD;
    else if (avm_local_read) done_word = avm_local_readdata;
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state               <= IDLE;
      sr                  <= '0;
      cnt                 <= '0;
      overlong            <= 1'b0;
      sle_q               <= 1'b0;
      ignore              <= 1'b0;
      rw                  <= 1'b0;
      wcnt                <= '0;
      resp                <= '0;
      rcnt                <= '0;
      ser_srdy            <= 1'b0;
      ser_sdo             <= 1'b0;
      avm_local_address   <= '0;
      avm_local_writedata <= '0;
      avm_local_write     <= 1'b0;
      avm_local_read      <= 1'b0;
      frame_err           <= 1'b0;
    end else begin
      sle_q     <= ser_sle;
      frame_err <= 1'b0;
      // A frame started while we are busy is flagged once and then ignored
      // until sle drops, so its tail cannot leak into IDLE as a new frame.
      if (!ser_sle) ignore <= 1'b0;
      if (locked_out && sle_rise) begin
        frame_err <= 1'b1;
        ignore    <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ser_sle && !ignore) begin
            sr       <= {{(FL-1){1'b0}}, ser_sdi};
            cnt      <= CW'(1);
            overlong <= 1'b0;
            state    <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (ser_sle) begin
            if (cnt == CW'(FL)) overlong <= 1'b1;
            else begin
              sr  <= {sr[FL-2:0], ser_sdi};
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (cnt == CW'(FL) && !overlong) begin
            rw                  <= sr[FL-1];
            avm_local_address   <= sr[FL-2 -: ADDR_W];
            avm_local_writedata <= sr[31:0];
            state               <= BUS_REQ;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        BUS_REQ: begin
          avm_local_write <= rw;
          avm_local_read  <= ~rw;
          wcnt            <= '0;
          state           <= BUS_WAIT;
        end
        BUS_WAIT: begin
          if (!avm_local_waitrequest || tmo) begin
            avm_local_write <= 1'b0;
            avm_local_read  <= 1'b0;
            ser_srdy        <= 1'b1;
            ser_sdo         <= done_word[31];
            resp            <= {done_word[30:0], 1'b0};
            rcnt            <= '0;
            if (tmo) frame_err <= 1'b1;
            state           <= RESP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: begin
          if (rcnt == 5'd31) begin
            ser_srdy <= 1'b0;
            ser_sdo  <= 1'b0;
            state    <= GAP;
          end else begin
            ser_sdo <= resp[31];
            resp    <= {resp[30:0], 1'b0};
            rcnt    <= rcnt + 5'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_serial_endpoint.sv
// Scoreboard bench for qsys_serial_endpoint: directed and random frames, a
// behavioural local-bus slave, and decoupled bus/response monitors.
module tb_qsys_serial_endpoint;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk, rst, sdi, sle, srdy, sdo, wr, rd, waitreq, ferr, busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  qsys_serial_endpoint #(.ADDR_W(32), .TIMEOUT(TMO), .ERR_WORD(ERR)) dut (
    .rsi_MRST_reset(rst), .csi_MCLK_clk(clk), .ser_sdi(sdi), .ser_sle(sle),
    .ser_srdy(srdy), .ser_sdo(sdo), .avm_local_address(addr),
    .avm_local_writedata(wdata), .avm_local_byteenable(be),
    .avm_local_write(wr), .avm_local_read(rd), .avm_local_readdata(rdata),
    .avm_local_waitrequest(waitreq), .frame_err(ferr), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    logic [31:0] a;
    logic [31:0] d;
    int          wait_n;
    logic [31:0] rdata;
  } txn_t;

  txn_t        bus_q[$];
  logic [31:0] resp_q[$];
  int          total = 0;
  int          bad = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  bit          abort = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Local-bus slave plus strobe monitor
  initial begin
    txn_t cur;
    bit   active;
    int   k;
    cur = '{rw: 1'b0, a: '0, d: '0, wait_n: 0, rdata: '0};
    active = 0; k = 0; waitreq = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; waitreq = 1'b0;
      end else if (wr || rd) begin
        if (!active) begin
          active = 1; k = 0;
          if (bus_q.size() == 0) begin
            chk("unexpected_strobe", 64'(bus_q.size()), 64'd1);
            cur = '{rw: 1'b0, a: '0, d: '0, wait_n: 0, rdata: '0};
          end else begin
            cur = bus_q.pop_front();
            chk("strobe_kind", {62'd0, wr, rd}, {62'd0, cur.rw, ~cur.rw});
            chk("bus_addr", {32'd0, addr}, {32'd0, cur.a});
            if (cur.rw) chk("bus_wdata", {32'd0, wdata}, {32'd0, cur.d});
          end
        end
        waitreq = (k < cur.wait_n);
        rdata   = cur.rdata;
        k++;
      end else begin
        if (active) begin
          active = 0;
          chk("strobe_len", 64'(k),
              64'((cur.wait_n >= int'(TMO)) ? int'(TMO) : cur.wait_n + 1));
        end
        waitreq = 1'b0;
      end
    end
  end

  // Serial response monitor
  initial begin
    logic [31:0] w, e;
    int nb;
    nb = 0; w = '0;
    forever begin
      @(negedge clk);
      if (srdy) begin
        w = {w[30:0], sdo};
        nb++;
      end else begin
        chk("sdo_idle", {63'd0, sdo}, 64'd0);
        if (nb != 0) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_response", 64'(resp_q.size()), 64'd1);
          end else begin
            e = resp_q.pop_front();
            if (abort) abort = 0;
            else begin
              chk("resp_len", 64'(nb), 64'd32);
              chk("resp_word", {32'd0, w}, {32'd0, e});
            end
          end
          nb = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (ferr) err_cnt++;
  end

  // Model: a frame is executed only if it is exactly 65 bits; a stall of
  // TMO or more cycles gives ERR and a frame_err; writes answer 0.
  task automatic issue(input bit rw, input logic [31:0] a, input logic [31:0] d,
                       input int nbits, input int wait_n, input logic [31:0] rv);
    logic [64:0] f;
    f = {rw, a, d};
    if (nbits == 65) begin
      bus_q.push_back('{rw: rw, a: a, d: d, wait_n: wait_n, rdata: rv});
      resp_q.push_back((wait_n >= int'(TMO)) ? ERR : (rw ? 32'h0 : rv));
      if (wait_n >= int'(TMO)) exp_err++;
    end else begin
      exp_err++;
    end
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sle = 1'b1;
      sdi = (i < 65) ? f[64 - i] : 1'($urandom);
    end
    @(negedge clk);
    sle = 1'b0; sdi = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    repeat (2) @(negedge clk);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, {63'd0, busy}, 64'd0);
    chk({name, "_frame_err"}, 64'(err_cnt), 64'(exp_err));
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input string name, input bit rw, input logic [31:0] a,
                     input logic [31:0] d, input int nbits, input int wait_n,
                     input logic [31:0] rv);
    issue(rw, a, d, nbits, wait_n, rv);
    wait_idle(name);
  endtask

  initial begin
    int n, r, nbits, wn;
    rst = 1'b1; sle = 1'b0; sdi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {57'd0, srdy, sdo, wr, rd, ferr, busy, 1'b0}, 64'd0);
    chk("reset_be", {60'd0, be}, 64'hF);
    chk("reset_bus", {addr, wdata}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run("write", 1'b1, 32'h10, 32'hA5A5_0F0F, 65, 0, 32'h0);
    run("read", 1'b0, 32'h20, 32'h0, 65, 3, 32'h1234_5678);
    run("short", 1'b1, 32'h30, 32'h1, 40, 0, 32'h0);
    run("long", 1'b0, 32'h40, 32'h2, 70, 0, 32'h0);
    run("one_bit", 1'b1, 32'h0, 32'h0, 1, 0, 32'h0);
    run("wait7", 1'b0, 32'h50, 32'h0, 65, 7, 32'hCAFE_F00D);
    run("timeout", 1'b0, 32'h60, 32'h0, 65, 100, 32'h5555_AAAA);
    run("timeout_wr", 1'b1, 32'h64, 32'h77, 65, 8, 32'h0);

    // sle raised while the bus transaction is stalled: flagged, ignored
    issue(1'b0, 32'h70, 32'h0, 65, 6, 32'h0BAD_F00D);
    n = 0;
    while (!(wr || rd) && n < 200) begin @(negedge clk); n++; end
    chk("intrude_strobe_seen", {63'd0, wr || rd}, 64'd1);
    exp_err++;
    repeat (4) begin @(negedge clk); sle = 1'b1; sdi = 1'($urandom); end
    @(negedge clk); sle = 1'b0; sdi = 1'b0;
    wait_idle("intrude");

    // reset in the middle of the response
    issue(1'b0, 32'h80, 32'h0, 65, 0, 32'hFFFF_0001);
    n = 0;
    while (!srdy && n < 200) begin @(negedge clk); n++; end
    chk("reset_resp_seen", {63'd0, srdy}, 64'd1);
    repeat (10) @(negedge clk);
    abort = 1;
    rst = 1'b1;
    #1;
    chk("midreset_outs", {59'd0, srdy, sdo, busy, wr, rd}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle("after_reset");
    run("post_reset_read", 1'b0, 32'h90, 32'h0, 65, 2, 32'h8765_4321);

    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      wn = int'($urandom_range(0, 5));
      nbits = 65;
      if (r == 7) nbits = int'($urandom_range(1, 64));
      else if (r == 8) nbits = int'($urandom_range(66, 72));
      else if (r == 9) wn = int'($urandom_range(7, 12));
      run("random", 1'($urandom), $urandom, $urandom, nbits, wn, $urandom);
    end

    chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
